// File: rtl/rs_systematic_encoder.sv
// rs_systematic_encoder
//   Serial systematic Reed-Solomon encoder over GF(2^8). Message bytes stream
//   through unchanged, then NSYM parity bytes (highest-order remainder term
//   first) follow. A single combinational GF multiplier walks the generator
//   taps one per cycle, so each message byte costs NSYM+1 cycles.
//
//   Optional build macro: RS_ENC_CW_COUNT_EN enables the 16-bit completed
//   codeword counter on cw_count; without it cw_count is tied to zero.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   prim_poly[8:0]          field polynomial (bits[7:0] used for reduction)
//   msg_len[7:0]            message bytes per codeword, sampled on start
//   cfg_we/cfg_addr/cfg_data generator coefficient g[k] write port (IDLE only)
//   start                   begin a codeword
//   in_valid/in_data/in_ready   message byte input handshake
//   out_valid/out_data/out_last/out_ready  codeword byte output handshake
//   busy                    high whenever not IDLE
//   done                    one-cycle pulse after the final parity handshake
//   cfg_err                 one-cycle pulse when start is rejected (length)
//   cw_count[15:0]          completed codeword count (optional)
module rs_systematic_encoder #(
    parameter int NSYM   = 32,
    parameter int CW_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  prim_poly,
    input  logic [7:0]  msg_len,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [15:0] cw_count
);

    localparam int TW = $clog2(NSYM);

    // DRAIN holds off the parity phase until the last message byte has left.
    typedef enum logic [2:0] {IDLE, MSG_IN, UPDATE, DRAIN, PARITY} state_t;

    state_t          state;
    logic [7:0]      par [NSYM];
    logic [7:0]      g   [NSYM];
    logic [7:0]      fb;
    logic [7:0]      count;
    logic [TW-1:0]   tap;
    logic [7:0]      prod;
    logic            unused_poly_msb;

    assign unused_poly_msb = prim_poly[8];

    // Shift-and-add GF(2^8) multiply, reducing by the low byte of prim_poly.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] poly);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa[7] ? ((aa << 1) ^ poly) : (aa << 1);
        end
        return acc;
    endfunction

    // The only multiplier: current tap coefficient times the feedback byte.
    assign prod     = gf_mul(g[tap], fb, prim_poly[7:0]);
    assign busy     = (state != IDLE);
    assign in_ready = (state == MSG_IN) && !out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NSYM; i++) begin
                par[i] <= 8'h00;
                g[i]   <= 8'h00;
            end
            fb        <= 8'h00;
            count     <= 8'h00;
            tap       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we && (32'(cfg_addr) < NSYM))
                        g[cfg_addr[TW-1:0]] <= cfg_data;
                    if (start) begin
                        if (32'(msg_len) <= CW_MAX - NSYM) begin
                            for (int i = 0; i < NSYM; i++) par[i] <= 8'h00;
                            count    <= msg_len;
                            out_last <= 1'b0;
                            if (msg_len == 8'h00) begin
                                tap   <= TW'(NSYM - 1);
                                state <= PARITY;
                            end else begin
                                state <= MSG_IN;
                            end
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                MSG_IN: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        fb        <= in_data ^ par[NSYM-1];
                        tap       <= TW'(NSYM - 1);
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    // Taps descend so par[tap-1] is still the old value here.
                    par[tap] <= ((tap != '0) ? par[tap - TW'(1)] : 8'h00) ^ prod;
                    if (tap == '0) begin
                        count <= count - 8'd1;
                        if (count == 8'd1) begin
                            tap <= TW'(NSYM - 1);
                            if (!out_valid || out_ready) state <= PARITY;
                            else                         state <= DRAIN;
                        end else begin
                            state <= MSG_IN;
                        end
                    end else begin
                        tap <= tap - TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= PARITY;
                    end
                end
                PARITY: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= par[NSYM-1];
                        out_last  <= (tap == '0);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        for (int i = NSYM - 1; i > 0; i--) par[i] <= par[i-1];
                        par[0] <= 8'h00;
                        if (tap == '0) begin
                            out_last <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            tap <= tap - TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_ENC_CW_COUNT_EN
    logic        last_hs;
    logic [15:0] cw_cnt;

    assign last_hs = (state == PARITY) && out_valid && out_ready && (tap == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cw_cnt <= 16'h0000;
        else if (last_hs) cw_cnt <= cw_cnt + 16'd1;
    end

    assign cw_count = cw_cnt;
`else
    assign cw_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rs_systematic_encoder.sv
// Bench for rs_systematic_encoder (NSYM=32). Expected codewords come from
// polynomial long division using log/antilog GF tables; the RS(255,223)
// case also checks that every syndrome of the received codeword is zero.
module tb_rs_systematic_encoder;
    localparam int NSYM = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [8:0]  prim_poly = 9'h11D;
    logic [7:0]  msg_len = 8'h00;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = 5'h00;
    logic [7:0]  cfg_data = 8'h00;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] cw_count;

    always #5 clk = ~clk;

    rs_systematic_encoder #(.NSYM(NSYM), .CW_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .prim_poly(prim_poly), .msg_len(msg_len),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy),
        .done(done), .cfg_err(cfg_err), .cw_count(cw_count)
    );

    int total = 0;
    int bad = 0;
    int stall_err = 0;
    int done_cnt = 0;
    int exp_cw = 0;
    bit rdy_rand = 0;

    logic [7:0] msg [0:254];
    logic [7:0] gc  [0:NSYM-1];
    logic [7:0] exp_t [0:509];
    int         log_t [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         last_q [$];

    // Output monitor: records handshaken beats, done pulses, stall violations.
    logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr && !(out_valid === 1'b1 && out_data === pd && out_last === pl))
                stall_err++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
            end
            if (done) done_cnt++;
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[log_t[a] + log_t[b]];
    endfunction

    function automatic int exp_cnt();
`ifdef RS_ENC_CW_COUNT_EN
        return exp_cw & 32'hFFFF;
`else
        return 0;
`endif
    endfunction

    // Codeword = message followed by remainder of m(x)*x^NSYM / g(x).
    function automatic void build_expected(input int len);
        logic [7:0] r [0:286];
        exp_q.delete();
        for (int i = 0; i < 287; i++) r[i] = (i < len) ? msg[i] : 8'h00;
        for (int i = 0; i < len; i++) begin
            logic [7:0] c;
            c = r[i];
            for (int j = 1; j <= NSYM; j++) r[i+j] = r[i+j] ^ gmul(c, gc[NSYM-j]);
        end
        for (int i = 0; i < len + NSYM; i++) exp_q.push_back(i < len ? msg[i] : r[i]);
    endfunction

    task automatic program_g();
        for (int k = 0; k < NSYM; k++) begin
            @(posedge clk); #1;
            cfg_we = 1'b1; cfg_addr = 5'(k); cfg_data = gc[k];
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_small_g();
        for (int k = 0; k < NSYM; k++) gc[k] = 8'h00;
        gc[3] = 8'h0F; gc[2] = 8'h36; gc[1] = 8'h78; gc[0] = 8'h40;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cw = 0;
    endtask

    task automatic run_cw(input int len, output bit to);
        int n;
        to = 0;
        got_q.delete(); last_q.delete();
        stall_err = 0; done_cnt = 0;
        @(posedge clk); #1;
        msg_len = 8'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < len && !to; i++) begin
            in_data = msg[i]; in_valid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                n++;
                if (n > 2000) begin to = 1; break; end
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 20000) begin @(posedge clk); n++; end
        if (done_cnt == 0) to = 1;
        else exp_cw++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [29:0] act;
        @(negedge clk);
        act = {in_ready, out_valid, out_data, out_last, busy, done, cfg_err, cw_count};
        total++;
        if (act !== 30'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
    endtask

    task automatic test_small_code();
        bit to;
        logic [31:0] tail;
        logic [31:0] lit;
        set_small_g();
        program_g();
        rdy_rand = 0;
        for (int pass = 0; pass < 3; pass++) begin
            int len;
            len = (pass == 2) ? 2 : 1;
            msg[0] = (pass == 0) ? 8'h01 : (pass == 1) ? 8'h02 : 8'h00;
            msg[1] = 8'h00;
            run_cw(len, to);
            build_expected(len);
            total++;
            if (to || got_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL small_beats p%0d: got %0d want %0d (timeout=%0d)", pass, got_q.size(), exp_q.size(), to);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                    bad++;
                    $display("FAIL small_byte p%0d[%0d]: got %h/%0d want %h/%0d", pass, i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
                end
            end
            if (pass < 2 && got_q.size() == 33) begin
                tail = {got_q[29], got_q[30], got_q[31], got_q[32]};
                lit  = (pass == 0) ? 32'h0F367840 : 32'h1E6CF080;
                total++;
                if (tail !== lit) begin
                    bad++;
                    $display("FAIL small_parity p%0d: got %h want %h", pass, tail, lit);
                end
            end
            total++;
            if (done_cnt != 1) begin
                bad++;
                $display("FAIL small_done p%0d: got %0d pulses want 1", pass, done_cnt);
            end
        end
    endtask

    task automatic test_rs255();
        bit to;
        logic [7:0] p [0:NSYM];
        p[0] = 8'h01;
        for (int j = 1; j <= NSYM; j++) p[j] = 8'h00;
        for (int i = 0; i < NSYM; i++)
            for (int j = i + 1; j >= 1; j--) begin
                p[j] = p[j-1] ^ gmul(p[j], exp_t[i]);
                if (j == 1) p[0] = gmul(p[0], exp_t[i]);
            end
        for (int k = 0; k < NSYM; k++) gc[k] = p[k];
        program_g();
        for (int i = 0; i < 223; i++) msg[i] = 8'($urandom);
        rdy_rand = 1;
        run_cw(223, to);
        rdy_rand = 0;
        build_expected(223);
        total++;
        if (to || got_q.size() != 255) begin
            bad++;
            $display("FAIL rs255_beats: got %0d want 255 (timeout=%0d)", got_q.size(), to);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                if (bad < 20) $display("FAIL rs255_byte[%0d]: got %h/%0d want %h/%0d", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        for (int i = 0; i < NSYM; i++) begin
            logic [7:0] s;
            s = 8'h00;
            foreach (got_q[n]) s = gmul(s, exp_t[i]) ^ got_q[n];
            total++;
            if (s !== 8'h00) begin
                bad++;
                $display("FAIL rs255_syndrome[%0d]: got %h want 00", i, s);
            end
        end
        total++;
        if (stall_err != 0) begin
            bad++;
            $display("FAIL rs255_stall: got %0d unstable beats want 0", stall_err);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL rs255_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_cfg();
        bit to;
        @(posedge clk); #1;
        msg_len = 8'd224; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_pulse: got err=%0d busy=%0d want err=1 busy=0", cfg_err, busy);
        end
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_clear: got err=%0d busy=%0d want err=0 busy=0", cfg_err, busy);
        end
        set_small_g();
        program_g();
        msg[0] = 8'h01;
        fork
            run_cw(1, to);
            begin
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (busy) break;
                end
                @(posedge clk); #1;
                cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 8'hAA;
                repeat (3) @(posedge clk);
                #1 cfg_we = 1'b0;
            end
        join
        build_expected(1);
        total++;
        if (to || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL busywrite_beats: got %0d want %0d (timeout=%0d)", got_q.size(), exp_q.size(), to);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL busywrite_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        // The ignored write must not have reached g[3] for a later codeword either.
        run_cw(1, to);
        total++;
        if (to || got_q.size() != 33 || got_q[29] !== 8'h0F) begin
            bad++;
            $display("FAIL busywrite_persist: got %h want 0f (timeout=%0d)", got_q.size() > 29 ? got_q[29] : 8'h00, to);
        end
    endtask

    task automatic test_zero_and_abort();
        bit to;
        logic [29:0] act;
        int n;
        run_cw(0, to);
        build_expected(0);
        total++;
        if (to || got_q.size() != NSYM) begin
            bad++;
            $display("FAIL zerolen_beats: got %0d want %0d (timeout=%0d)", got_q.size(), NSYM, to);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == NSYM - 1)) begin
                bad++;
                $display("FAIL zerolen_byte[%0d]: got %h/%0d want %h/%0d", i, got_q[i], last_q[i], exp_q[i], i == NSYM - 1);
            end
        end
        // Abort partway through the tap walk of the first message byte.
        @(posedge clk); #1;
        msg_len = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_data = 8'h5A; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n > 100) break;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_midupdate: got busy=%0d in_ready=%0d want 1/0", busy, in_ready);
        end
        #1 rst_n = 1'b0;
        exp_cw = 0;
        #1;
        act = {in_ready, out_valid, out_data, out_last, busy, done, cfg_err, cw_count};
        total++;
        if (act !== 30'h0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", act);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        set_small_g();
        program_g();
        for (int i = 0; i < 3; i++) msg[i] = 8'($urandom);
        run_cw(3, to);
        build_expected(3);
        total++;
        if (to || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL after_abort_beats: got %0d want %0d (timeout=%0d)", got_q.size(), exp_q.size(), to);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL after_abort_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cw_count();
        bit to;
        apply_reset();
        @(negedge clk);
        total++;
        if (cw_count !== 16'h0000) begin
            bad++;
            $display("FAIL cwcount_reset: got %0d want 0", cw_count);
        end
        set_small_g();
        program_g();
        rdy_rand = 1;
        for (int c = 0; c < 3; c++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            run_cw(len, to);
            total++;
            if (to || cw_count !== 16'(exp_cnt())) begin
                bad++;
                $display("FAIL cwcount_%0d: got %0d want %0d (timeout=%0d)", c, cw_count, exp_cnt(), to);
            end
        end
        rdy_rand = 0;
    endtask

    initial begin
        logic [8:0] x;
        x = 9'h001;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x[7:0];
            exp_t[i+255] = x[7:0];
            log_t[x[7:0]] = i;
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
        log_t[0] = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        test_small_code();
        test_rs255();
        test_cfg();
        test_zero_and_abort();
        test_cw_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
